// File: rtl/bypass_rf_sequencer_if.sv
// Bus between the bypass register-file sequencer and its surroundings: decode, register file,
// writeback and execute. The master modport is the sequencer's view.
interface bypass_rf_sequencer_if #(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 32,
  parameter int unsigned name_width = 3
) ();
  // Decode side
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [addr_width-1:0] IN_RS1;
  logic [addr_width-1:0] IN_RS2;
  logic [addr_width-1:0] IN_RD;
  logic                  IN_HAS_RD;
  // Register-file read reservation and read data
  logic [addr_width-1:0] ADDR_1;
  logic [addr_width-1:0] ADDR_2;
  logic                  RRESE_1;
  logic                  RRESE_2;
  logic                  RRES_READY_1;
  logic                  RRES_READY_2;
  logic [name_width-1:0] RNAME_OUT_1;
  logic [name_width-1:0] RNAME_OUT_2;
  logic [name_width-1:0] RD_NAME_1;
  logic [name_width-1:0] RD_NAME_2;
  logic [data_width-1:0] D_OUT_1;
  logic [data_width-1:0] D_OUT_2;
  logic                  VALID_OUT_1;
  logic                  VALID_OUT_2;
  logic                  FE_1;
  logic                  FE_2;
  // Register-file write allocation, write and free
  logic [addr_width-1:0] ADDR_IN;
  logic                  ALLOC_E;
  logic                  ALLOC_READY;
  logic [name_width-1:0] NAME_OUT;
  logic [name_width-1:0] NAME_IN_1;
  logic [data_width-1:0] D_IN_1;
  logic                  WE_1;
  logic [name_width-1:0] W_F;
  logic                  WFE;
  logic                  F_READY;
  // Execute writeback
  logic                  WB_VALID;
  logic [name_width-1:0] WB_NAME;
  logic [data_width-1:0] WB_DATA;
  // Downstream operand handshake
  logic                  OP_VALID;
  logic                  OP_READY;
  logic [data_width-1:0] OP_A;
  logic [data_width-1:0] OP_B;
  logic [name_width-1:0] OP_NAME;
  logic                  OP_HAS_RD;

  modport master (
    input  IN_VALID, IN_RS1, IN_RS2, IN_RD, IN_HAS_RD,
    input  RRES_READY_1, RRES_READY_2, RNAME_OUT_1, RNAME_OUT_2,
    input  D_OUT_1, D_OUT_2, VALID_OUT_1, VALID_OUT_2,
    input  ALLOC_READY, NAME_OUT, F_READY,
    input  WB_VALID, WB_NAME, WB_DATA, OP_READY,
    output IN_READY, ADDR_1, ADDR_2, RRESE_1, RRESE_2, RD_NAME_1, RD_NAME_2, FE_1, FE_2,
    output ADDR_IN, ALLOC_E, NAME_IN_1, D_IN_1, WE_1, W_F, WFE,
    output OP_VALID, OP_A, OP_B, OP_NAME, OP_HAS_RD
  );

  modport slave (
    output IN_VALID, IN_RS1, IN_RS2, IN_RD, IN_HAS_RD,
    output RRES_READY_1, RRES_READY_2, RNAME_OUT_1, RNAME_OUT_2,
    output D_OUT_1, D_OUT_2, VALID_OUT_1, VALID_OUT_2,
    output ALLOC_READY, NAME_OUT, F_READY,
    output WB_VALID, WB_NAME, WB_DATA, OP_READY,
    input  IN_READY, ADDR_1, ADDR_2, RRESE_1, RRESE_2, RD_NAME_1, RD_NAME_2, FE_1, FE_2,
    input  ADDR_IN, ALLOC_E, NAME_IN_1, D_IN_1, WE_1, W_F, WFE,
    input  OP_VALID, OP_A, OP_B, OP_NAME, OP_HAS_RD
  );
endinterface

// File: rtl/bypass_rf_sequencer.sv
// In-order client sequencer for the bypass register file: reserve, wait for operands, issue,
// route writebacks and free write names in allocation order.
// Optional stall counters (STALL_WAIT, STALL_RES) are built when BYPASS_RF_SEQ_STATS_EN is defined.
module bypass_rf_sequencer #(
  parameter int unsigned addr_width = 5,
  parameter int unsigned data_width = 32,
  parameter int unsigned name_width = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
`ifdef BYPASS_RF_SEQ_STATS_EN
  output logic [31:0]           STALL_WAIT,
  output logic [31:0]           STALL_RES,
`endif
  bypass_rf_sequencer_if.master bus
);

  localparam int unsigned NumNames = 1 << name_width;
  localparam logic [name_width:0] CountFull = NumNames[name_width:0];

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StIssue = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [name_width-1:0] rname1_q, rname1_d;
  logic [name_width-1:0] rname2_q, rname2_d;
  logic [name_width-1:0] name_q, name_d;
  logic                  has_rd_q, has_rd_d;
  logic [data_width-1:0] op_a_q, op_a_d;
  logic [data_width-1:0] op_b_q, op_b_d;
  logic [name_width:0]   count_q, count_d;
  logic [name_width-1:0] cptr_q, cptr_d;
  logic [NumNames-1:0]   written_q, written_d;

  logic                  res_ok;
  logic                  in_ready;
  logic                  accept;
  logic                  alloc;
  logic                  op_fire;
  logic [name_width-1:0] wb_off;
  logic                  wb_in_win;
  logic                  we;
  logic                  wfe;
  logic                  free;

  always_comb begin
    res_ok   = bus.RRES_READY_1 & bus.RRES_READY_2 &
               (~bus.IN_HAS_RD | (bus.ALLOC_READY & (count_q < CountFull)));
    in_ready = (state_q == StIdle) & res_ok & ~RST;
    accept   = bus.IN_VALID & in_ready;
    alloc    = accept & bus.IN_HAS_RD;
    op_fire  = (state_q == StIssue) & bus.OP_READY & ~RST;
    // Live names occupy [cptr, cptr+count) modulo the ring size.
    wb_off    = bus.WB_NAME - cptr_q;
    wb_in_win = {1'b0, wb_off} < count_q;
    we        = bus.WB_VALID & ~written_q[bus.WB_NAME] & wb_in_win & ~RST;
    wfe       = (count_q != '0) & written_q[cptr_q] & ~RST;
    free      = wfe & bus.F_READY;
  end

  always_comb begin
    state_d  = state_q;
    rname1_d = rname1_q;
    rname2_d = rname2_q;
    name_d   = name_q;
    has_rd_d = has_rd_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rname1_d = bus.RNAME_OUT_1;
          rname2_d = bus.RNAME_OUT_2;
          name_d   = bus.NAME_OUT;
          has_rd_d = bus.IN_HAS_RD;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (bus.VALID_OUT_1 && bus.VALID_OUT_2) begin
          op_a_d  = bus.D_OUT_1;
          op_b_d  = bus.D_OUT_2;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.OP_READY) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    written_d = written_q;
    if (we)   written_d[bus.WB_NAME] = 1'b1;
    if (free) written_d[cptr_q] = 1'b0;
    cptr_d = free ? cptr_q + 1'b1 : cptr_q;
    case ({alloc, free})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      rname1_q  <= '0;
      rname2_q  <= '0;
      name_q    <= '0;
      has_rd_q  <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      count_q   <= '0;
      cptr_q    <= '0;
      written_q <= '0;
    end else begin
      state_q   <= state_d;
      rname1_q  <= rname1_d;
      rname2_q  <= rname2_d;
      name_q    <= name_d;
      has_rd_q  <= has_rd_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      count_q   <= count_d;
      cptr_q    <= cptr_d;
      written_q <= written_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.ADDR_1    = bus.IN_RS1;
  assign bus.ADDR_2    = bus.IN_RS2;
  assign bus.RRESE_1   = accept;
  assign bus.RRESE_2   = accept;
  assign bus.RD_NAME_1 = rname1_q;
  assign bus.RD_NAME_2 = rname2_q;
  assign bus.FE_1      = op_fire;
  assign bus.FE_2      = op_fire;
  assign bus.ADDR_IN   = bus.IN_RD;
  assign bus.ALLOC_E   = alloc;
  assign bus.NAME_IN_1 = bus.WB_NAME;
  assign bus.D_IN_1    = bus.WB_DATA;
  assign bus.WE_1      = we;
  assign bus.W_F       = cptr_q;
  assign bus.WFE       = wfe;
  assign bus.OP_VALID  = (state_q == StIssue) & ~RST;
  assign bus.OP_A      = op_a_q;
  assign bus.OP_B      = op_b_q;
  assign bus.OP_NAME   = name_q;
  assign bus.OP_HAS_RD = has_rd_q;

`ifdef BYPASS_RF_SEQ_STATS_EN
  logic [31:0] stall_wait_q, stall_wait_d;
  logic [31:0] stall_res_q, stall_res_d;

  always_comb begin
    stall_wait_d = stall_wait_q;
    stall_res_d  = stall_res_q;
    if ((state_q == StWait) && (stall_wait_q != '1)) stall_wait_d = stall_wait_q + 32'd1;
    if ((state_q == StIdle) && bus.IN_VALID && !res_ok && (stall_res_q != '1)) begin
      stall_res_d = stall_res_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_wait_q <= '0;
      stall_res_q  <= '0;
    end else begin
      stall_wait_q <= stall_wait_d;
      stall_res_q  <= stall_res_d;
    end
  end

  assign STALL_WAIT = stall_wait_q;
  assign STALL_RES  = stall_res_q;
`endif

endmodule
